fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 131 +++++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------------------------------------------------------------------
// Instruction fetch sequencer for a small 16-bit machine with an 8-bit
// address space. Fetches one word per cycle from a combinational-read
// instruction memory into an instruction register. It handles beqz
// redirects (opcode 4'b1001, 4-bit signed PC-relative offset) and halt
// (opcode 4'b1100).
//
// Ports
//   clk          : single clock, all state changes on rising edge
//   reset        : synchronous, active-high reset
//   start        : one-cycle pulse; begins execution at address 0 from IDLE/HALT
//   stall        : datapath back-pressure; freezes all sequencer state
//   branch_taken : datapath reports the beqz condition in ir is true
//   imem_addr    : instruction memory address (equals pc)
//   imem_inst    : instruction word returned for imem_addr (same cycle)
//   ir           : registered instruction presented to the datapath
//   ir_pc        : address ir was fetched from
//   ir_valid     : ir holds a live instruction this cycle
//   halted       : high while in HALT
//   retired      : valid instructions presented since start (saturating)
// ---------------------------------------------------------------------------
module fetch_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_taken,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_inst,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    output logic        halted,
    output logic [15:0] retired
);

    localparam logic [3:0] OP_BEQZ = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [7:0]  pc_reg;
    logic [15:0] ir_reg;
    logic [7:0]  ir_pc_reg;
    logic        ir_valid_reg;
    logic        halted_reg;
    logic [15:0] retired_reg;

    logic        redirect;
    logic        halt_hit;
    logic [7:0]  offset_sext;
    logic [7:0]  branch_target;

    // Redirect/halt only act on a live instruction in a non-stalled cycle.
    assign redirect = ir_valid_reg && (ir_reg[15:12] == OP_BEQZ) && branch_taken && !stall;
    assign halt_hit = ir_valid_reg && (ir_reg[15:12] == OP_HALT) && !stall;

    // Sign-extend the 4-bit beqz offset to 8 bits.
    assign offset_sext[3:0] = ir_reg[3:0];
    generate
        for (genvar gi = 4; gi < 8; gi++) begin : g_sext
            assign offset_sext[gi] = ir_reg[3];
        end
    endgenerate

    // 8-bit add wraps modulo 256 naturally.
    assign branch_target = ir_pc_reg + offset_sext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pc_reg       <= 8'd0;
            ir_reg       <= 16'd0;
            ir_pc_reg    <= 8'd0;
            ir_valid_reg <= 1'b0;
            halted_reg   <= 1'b0;
            retired_reg  <= 16'd0;
        end else begin
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg    <= FETCH;
                        pc_reg       <= 8'd0;
                        ir_valid_reg <= 1'b0;
                        retired_reg  <= 16'd0;
                        halted_reg   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (!stall) begin
                        // The instruction currently in ir is consumed this cycle.
                        if (ir_valid_reg && (retired_reg != 16'hFFFF)) begin
                            retired_reg <= retired_reg + 16'd1;
                        end
                        if (halt_hit) begin
                            state_reg    <= HALT;
                            halted_reg   <= 1'b1;
                            ir_valid_reg <= 1'b0;
                        end else if (redirect) begin
                            // The word read at pc this cycle is dropped.
                            pc_reg       <= branch_target;
                            ir_valid_reg <= 1'b0;
                        end else begin
                            ir_reg       <= imem_inst;
                            ir_pc_reg    <= pc_reg;
                            ir_valid_reg <= 1'b1;
                            pc_reg       <= pc_reg + 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign imem_addr = pc_reg;
    assign ir        = ir_reg;
    assign ir_pc     = ir_pc_reg;
    assign ir_valid  = ir_valid_reg;
    assign halted    = halted_reg;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. A behavioural model of the
// sequencer is advanced on every rising edge and compared with the DUT.
// Directed scenarios (Fib(3) program with a small datapath model, stall on
// a taken branch, reset mid-run, restart from HALT, start while fetching,
// address wrap) add literal expectations that pin the model.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  imem_addr;
    logic [15:0] imem_inst;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;
    logic [15:0] retired;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stall        (stall),
        .branch_taken (branch_taken),
        .imem_addr    (imem_addr),
        .imem_inst    (imem_inst),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .halted       (halted),
        .retired      (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory (combinational read)
    logic [15:0] mem [256];
    always_comb imem_inst = mem[imem_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_running;   // executing (FETCH)
    bit m_halt;      // stopped by a halt instruction
    int m_pc;
    int m_ir;
    int m_ir_pc;
    bit m_valid;
    int m_retired;

    initial begin
        m_running = 0; m_halt = 0; m_pc = 0; m_ir = 0;
        m_ir_pc = 0; m_valid = 0; m_retired = 0;
    end

    task automatic model_step();
        int op;
        int off;
        op = (m_ir >> 12) & 15;
        off = m_ir & 15;
        if (off >= 8) off = off - 16;
        if (reset) begin
            m_running = 0; m_halt = 0; m_pc = 0; m_ir = 0;
            m_ir_pc = 0; m_valid = 0; m_retired = 0;
        end else if (!m_running) begin
            if (start) begin
                m_running = 1; m_halt = 0; m_pc = 0; m_valid = 0; m_retired = 0;
            end
        end else if (!stall) begin
            if (m_valid && m_retired < 65535) m_retired = m_retired + 1;
            if (m_valid && op == 12) begin
                m_running = 0; m_halt = 1; m_valid = 0;
            end else if (m_valid && op == 9 && branch_taken) begin
                m_pc = (m_ir_pc + off + 256) % 256;
                m_valid = 0;
            end else begin
                m_ir = int'(mem[m_pc]);
                m_ir_pc = m_pc;
                m_valid = 1;
                m_pc = (m_pc + 1) % 256;
            end
        end
    endtask

    // Single compare process: advance model at the edge, compare just after.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("cyc_imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("cyc_ir",        32'(ir),        32'(m_ir));
        chk("cyc_ir_pc",     32'(ir_pc),     32'(m_ir_pc));
        chk("cyc_ir_valid",  32'(ir_valid),  32'(m_valid));
        chk("cyc_halted",    32'(halted),    32'(m_halt));
        chk("cyc_retired",   32'(retired),   32'(m_retired));
    end

    // ---------------- datapath model (stimulus) ----------------
    // r0 is always zero. Ops: 1 li rd,imm ; 2 add rd,rs,rt ; 3 dec rd ;
    // 9 beqz rs,off ; C halt. branch_taken reports reg[ir[11:8]]==0 for any
    // opcode so that the sequencer must ignore it on non-beqz words.
    int regs [16];

    task automatic dp_reset();
        for (int i = 0; i < 16; i++) regs[i] = 0;
    endtask

    // Called at a negedge after stall for the coming edge has been chosen.
    task automatic dp_cycle();
        int op, d, s, t;
        op = int'(ir[15:12]); d = int'(ir[11:8]); s = int'(ir[7:4]); t = int'(ir[3:0]);
        branch_taken = (regs[d] == 0);
        if (ir_valid && !stall) begin
            case (op)
                1: regs[d] = int'(ir[7:0]);
                2: regs[d] = regs[s] + regs[t];
                3: regs[d] = regs[d] - 1;
                default: ;
            endcase
            regs[0] = 0;
        end
    endtask

    task automatic load_fib();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1100;  // li r1,0      a
        mem[1] = 16'h1201;  // li r2,1      b
        mem[2] = 16'h1303;  // li r3,3      n
        mem[3] = 16'h9306;  // beqz r3,+6 -> 9
        mem[4] = 16'h2412;  // r4 = a+b
        mem[5] = 16'h2120;  // a = b
        mem[6] = 16'h2240;  // b = t
        mem[7] = 16'h3300;  // n--
        mem[8] = 16'h900B;  // beqz r0,-5 -> 3
        mem[9] = 16'hC000;  // halt
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    initial begin
        int scnt, after_rel, ret0, pc0;
        bit sdone, done;

        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        load_fib();
        dp_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ir_valid", 32'(ir_valid), 0);
        chk("idle_retired",  32'(retired),  0);
        chk("idle_addr",     32'(imem_addr), 0);
        chk("idle_halted",   32'(halted),   0);

        // ---- Fib(3) run, with a 3-cycle stall on the first taken beqz at 8 ----
        @(negedge clk); start = 1'b1;
        scnt = 0; sdone = 0; after_rel = 0; done = 0; ret0 = 0; pc0 = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (halted) begin
                done = 1;
            end else begin
                if (after_rel == 1) begin
                    chk("redir_bubble_valid", 32'(ir_valid), 0);
                    chk("redir_retired",      32'(retired), 32'(ret0 + 1));
                    after_rel = 2;
                end else if (after_rel == 2) begin
                    chk("redir_target_pc", 32'(ir_pc), 3);
                    chk("redir_target_ir", 32'(ir), 32'h9306);
                    after_rel = 3;
                end
                stall = 1'b0;
                if (!sdone && ir_valid && ir == 16'h900B) begin
                    if (scnt == 0) begin
                        ret0 = int'(retired); pc0 = int'(imem_addr);
                        chk("beqz_at_8", 32'(ir_pc), 8);
                    end else begin
                        chk("stall_retired", 32'(retired), 32'(ret0));
                        chk("stall_pc",      32'(imem_addr), 32'(pc0));
                    end
                    if (scnt < 3) begin
                        stall = 1'b1; scnt++;
                    end else begin
                        sdone = 1; after_rel = 1;
                    end
                end
                dp_cycle();
            end
        end
        chk("fib_halted",  32'(halted), 1);
        chk("fib_ir_pc",   32'(ir_pc), 9);
        chk("fib_retired", 32'(retired), 23);
        chk("fib_result",  32'(regs[1]), 2);
        $display("scenario fib: halted=%0d ir_pc=%0d retired=%0d", halted, ir_pc, retired);

        // ---- start from HALT restarts at 0 and clears retired ----
        dp_reset();
        pulse_start();
        chk("restart_halted",  32'(halted), 0);
        chk("restart_retired", 32'(retired), 0);
        chk("restart_addr",    32'(imem_addr), 0);
        $display("scenario restart from HALT: addr=%0d retired=%0d", imem_addr, retired);

        // ---- reset while fetching at pc=5 ----
        done = 0;
        for (int cyc = 0; cyc < 30 && !done; cyc++) begin
            @(negedge clk);
            if (imem_addr == 8'd5) done = 1;
            else dp_cycle();
        end
        chk("reach_pc5", 32'(imem_addr), 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ir",       32'(ir), 0);
        chk("rst_ir_pc",    32'(ir_pc), 0);
        chk("rst_ir_valid", 32'(ir_valid), 0);
        chk("rst_retired",  32'(retired), 0);
        chk("rst_addr",     32'(imem_addr), 0);
        @(negedge clk);
        chk("rst_hold_valid", 32'(ir_valid), 0);
        pulse_start();
        @(negedge clk);
        chk("resume_ir_pc", 32'(ir_pc), 0);
        chk("resume_ir",    32'(ir), 32'h1100);
        chk("resume_valid", 32'(ir_valid), 1);
        $display("scenario reset mid-fetch: resume ir_pc=%0d ir=%h", ir_pc, ir);

        // ---- NOP memory: start during FETCH, then wrap through 255 ----
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        branch_taken = 1'b1;   // must be ignored on non-beqz words
        pulse_start();
        done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (imem_addr == 8'd20) done = 1;
            else @(negedge clk);
        end
        chk("reach_pc20", 32'(imem_addr), 20);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_fetch_addr",    32'(imem_addr), 21);
        chk("start_in_fetch_retired", 32'(retired), 20);
        $display("scenario start in FETCH: addr=%0d retired=%0d", imem_addr, retired);

        done = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            if (ir_valid && ir_pc == 8'd254) done = 1;
            else @(negedge clk);
        end
        chk("wrap_ir_pc_254", 32'(ir_pc), 254);
        chk("wrap_addr_255",  32'(imem_addr), 255);
        @(negedge clk);
        chk("wrap_ir_pc_255", 32'(ir_pc), 255);
        chk("wrap_addr_0",    32'(imem_addr), 0);
        @(negedge clk);
        chk("wrap_ir_pc_0",   32'(ir_pc), 0);
        @(negedge clk);
        chk("wrap_ir_pc_1",   32'(ir_pc), 1);
        chk("wrap_retired",   32'(retired), 257);
        $display("scenario wrap: ir_pc=%0d addr=%0d retired=%0d", ir_pc, imem_addr, retired);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
